fetch_redirect_unit: RTL
========================

# fetch_redirect_unit

Instruction-fetch front end for the pipelined RISC-V core. It owns the fetch PC (PCF) and runs a request/acknowledge handshake with a variable-latency instruction memory. It fills the IF/ID pipeline register through a one-entry skid buffer. It also consumes the 2-bit EX-stage redirect code PCSrcE, steering PCF to the branch/jal or jalr target and flushing the instructions already fetched down the wrong path.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on InstrD when the D slot is empty (addi x0,x0,0)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous and active-high
- PCSrcE  in  2  redirect code: 00 sequential, 01 PCTargetE (branch/jal), 10 ALUResultE (jalr), 11 reserved, treated as 00
- PCTargetE  in  32  branch/jal target from EX
- ALUResultE  in  32  jalr target from EX; bit 0 is forced to 0 before use
- StallD  in  1  hazard unit holds the IF/ID register
- ImemReq  out  1  fetch request
- ImemAddr  out  32  fetch address; equals PCF
- ImemAck  in  1  memory accepts the request and returns data this cycle; ignored unless ImemReq=1
- ImemRdata  in  32  instruction word, valid with ImemAck
- InstrD, PCD, PCPlus4D  out  32 each  IF/ID register contents
- ValidD  out  1  IF/ID holds a real instruction
- FlushD, FlushE  out  1 each  combinational; high in any cycle where PCSrcE is 01 or 10

## Operation
- State machine:
  - REQ: ImemReq=1.
  - HOLD: a word is buffered while StallD=1; ImemReq=0.
- Sticky drop flag: set when a redirect occurs while ImemReq=1 and ImemAck=0. The next ack is then discarded, and the flag clears on that ack.
- Handshake: ImemReq stays high and ImemAddr stays stable until ImemAck. A request is never withdrawn, even across a redirect.
- Accepted word (ack, drop=0, no redirect this cycle):
  - StallD=0: InstrD←ImemRdata, PCD←PCF, PCPlus4D←PCF+4, ValidD←1, PCF←PCF+4; stay in REQ.
  - StallD=1: capture word and PC in the skid buffer, PCF←PCF+4, go to HOLD.
- HOLD with StallD=0: transfer the buffer into IF/ID, go to REQ.
- Redirect (PCSrcE=01/10), highest priority:
  - PCF←target.
  - IF/ID cleared: ValidD←0, InstrD←NOP_INSTR. This overrides StallD.
  - Skid buffer discarded; HOLD→REQ.
  - An ack arriving in the same cycle is discarded and does not set drop.
  - When drop is set, the new address is presented on the cycle after the stale ack.
- No redirect and StallD=1: IF/ID holds its value.
- PC arithmetic is modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: PCF=RESET_PC, state REQ, drop=0, ImemReq=0 during the rst cycle, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- First ImemReq is in the first cycle after rst deasserts.
- A zero-wait memory (ack in the same cycle as the request) gives one instruction per cycle. The word appears on InstrD one cycle after its ack.
- Redirect-to-target-request latency:
  - 1 cycle with no request outstanding, or with an ack in the redirect cycle.
  - Otherwise the stale-ack cycle plus 1.
- FlushD/FlushE are purely combinational from PCSrcE, with zero latency.
- Reset asserted mid-transaction returns every register to its reset value and clears drop. Any late ImemAck is ignored because ImemReq=0.

## Test plan
- Reset, then ImemAck tied to 1 with Rdata=addr: PCD steps 0,4,8,12 on consecutive cycles, and ValidD=1 from cycle 2.
- Ack delayed 3 cycles: ImemAddr held at 0x8 for all 3 cycles, InstrD updates once, no duplicate or skipped PC.
- StallD=1 for 4 cycles while an ack arrives: IF/ID is frozen, the word is held in HOLD with ImemReq=0, and it appears in the cycle after StallD falls with the correct PCD.
- PCSrcE=01, PCTargetE=0x100 while the ack for 0x20 is outstanding:
  - FlushD=FlushE=1 and ValidD=0 next cycle.
  - Stale 0x20 data never reaches InstrD.
  - Next request is for 0x100.
- PCSrcE=10 with ALUResultE=0x205 and an ack in the same cycle: ImemAddr=0x204 next cycle and the acked word is discarded. PCSrcE=11 behaves as sequential.
- rst pulsed during a pending request, then PCF=0xFFFF_FFFC: outputs return to reset values, and after the next fetches PCF wraps to 0x0.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit
//   Instruction-fetch front end. Owns the fetch PC, runs a req/ack handshake
//   with a variable-latency instruction memory, fills the IF/ID register
//   through a one-entry skid buffer, and applies EX-stage redirects.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   PCSrcE              00 seq, 01 PCTargetE, 10 ALUResultE (jalr), 11 = seq
//   PCTargetE           branch/jal target
//   ALUResultE          jalr target (bit 0 cleared before use)
//   StallD              hold the IF/ID register
//   ImemReq, ImemAddr   fetch request and address (address == PCF)
//   ImemAck, ImemRdata  memory accept + instruction word in the same cycle
//   InstrD, PCD,
//   PCPlus4D, ValidD    IF/ID register contents
//   FlushD, FlushE      combinational flush, high on any redirect
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  input  logic        StallD,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FlushD,
  output logic        FlushE
);

  typedef enum logic {
    REQ  = 1'b0,  // request outstanding / issuing
    HOLD = 1'b1   // a fetched word waits in the skid buffer for StallD to drop
  } fetchStateT;

  fetchStateT  state, nextState;
  logic [31:0] pcF;
  logic        drop;         // next ack belongs to a squashed request
  logic [31:0] redirTarget;  // where to go once the stale ack has arrived
  logic [31:0] skidInstr;
  logic [31:0] skidPc;

  logic        redirect;
  logic [31:0] target;
  logic        ackFire;
  logic        accept;

  assign ImemAddr = pcF;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    redirect  = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    target    = (PCSrcE == 2'b01) ? PCTargetE : {ALUResultE[31:1], 1'b0};
    FlushD    = redirect;
    FlushE    = redirect;
    ImemReq   = !rst && (state == REQ);
    ackFire   = ImemReq && ImemAck;
    // A word is kept only if it belongs to the current path.
    accept    = ackFire && !drop && !redirect;
    nextState = state;
    case (state)
      REQ:  if (accept && StallD) nextState = HOLD;
      HOLD: if (redirect || !StallD) nextState = REQ;
      default: nextState = REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pcF         <= RESET_PC;
      drop        <= 1'b0;
      redirTarget <= 32'h0;
      InstrD      <= NOP_INSTR;
      PCD         <= 32'h0;
      PCPlus4D    <= 32'h0;
      ValidD      <= 1'b0;
    end else begin
      state <= nextState;
      if (redirect) begin
        // Squash IF/ID even under StallD; the wrong-path word must not issue.
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
        if (ImemReq && !ImemAck) begin
          // The request cannot be withdrawn: keep the address stable, eat the
          // eventual ack, and only then move to the target.
          drop        <= 1'b1;
          redirTarget <= target;
        end else begin
          pcF  <= target;
          drop <= 1'b0;
        end
      end else begin
        if (ackFire && drop) begin
          drop <= 1'b0;
          pcF  <= redirTarget;
        end else if (accept) begin
          pcF <= pcF + 32'd4;
        end

        if (!StallD) begin
          if (state == HOLD) begin
            InstrD   <= skidInstr;
            PCD      <= skidPc;
            PCPlus4D <= skidPc + 32'd4;
            ValidD   <= 1'b1;
          end else if (accept) begin
            InstrD   <= ImemRdata;
            PCD      <= pcF;
            PCPlus4D <= pcF + 32'd4;
            ValidD   <= 1'b1;
          end else begin
            // Nothing fetched this cycle: feed a bubble so no word repeats.
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
          end
        end
      end
    end
  end

  // NOTE: the skid buffer is a data-only store that is read solely in HOLD,
  // which is always entered by writing it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && StallD) begin
      skidInstr <= ImemRdata;
      skidPc    <= pcF;
    end
  end

endmodule
